pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Five-stage MIPS-subset control path: combinational D-stage decode, control
// pipeline registers D->E->M->W, a retired-instruction counter and a sticky illegal flag.
module pipeline_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opD,
  input  logic [5:0]  functD,
  input  logic        flushE,
  output logic        jumpD,
  output logic        branchD,
  output logic        regwriteE,
  output logic        regwriteM,
  output logic        regwriteW,
  output logic        memtoregE,
  output logic        memtoregM,
  output logic        memtoregW,
  output logic        memwriteM,
  output logic [2:0]  alucontrolE,
  output logic        alusrcE,
  output logic        regdstE,
  output logic        illegalD,
  output logic        illegal_seen,
  output logic [31:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
    logic       valid;
  } e_stage_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic valid;
  } m_stage_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic valid;
  } w_stage_t;

  logic       dec_regwrite;
  logic       dec_regdst;
  logic       dec_alusrc;
  logic       dec_branch;
  logic       dec_memwrite;
  logic       dec_memtoreg;
  logic       dec_jump;
  logic [2:0] dec_alucontrol;
  logic       dec_illegal;
  logic       rtype_ok;
  logic [2:0] rtype_alu;

  e_stage_t    e_d, e_q;
  m_stage_t    m_d, m_q;
  w_stage_t    w_d, w_q;
  logic [31:0] instret_d, instret_q;
  logic        illegal_seen_d, illegal_seen_q;

  // D-stage decode; any unsupported encoding leaves every field at zero
  always_comb begin
    dec_regwrite   = 1'b0;
    dec_regdst     = 1'b0;
    dec_alusrc     = 1'b0;
    dec_branch     = 1'b0;
    dec_memwrite   = 1'b0;
    dec_memtoreg   = 1'b0;
    dec_jump       = 1'b0;
    dec_alucontrol = 3'b000;
    dec_illegal    = 1'b0;
    rtype_ok       = 1'b1;
    rtype_alu      = 3'b000;
    case (functD)
      6'b100000: rtype_alu = 3'b010;
      6'b100010: rtype_alu = 3'b110;
      6'b100100: rtype_alu = 3'b000;
      6'b100101: rtype_alu = 3'b001;
      6'b101010: rtype_alu = 3'b111;
      default:   rtype_ok  = 1'b0;
    endcase
    case (opD)
      OP_RTYPE: begin
        if (rtype_ok) begin
          dec_regwrite   = 1'b1;
          dec_regdst     = 1'b1;
          dec_alucontrol = rtype_alu;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_LW: begin
        dec_regwrite   = 1'b1;
        dec_alusrc     = 1'b1;
        dec_memtoreg   = 1'b1;
        dec_alucontrol = 3'b010;
      end
      OP_SW: begin
        dec_memwrite   = 1'b1;
        dec_alusrc     = 1'b1;
        dec_alucontrol = 3'b010;
      end
      OP_BEQ: begin
        dec_branch     = 1'b1;
        dec_alucontrol = 3'b110;
      end
      OP_ADDI: begin
        dec_regwrite   = 1'b1;
        dec_alusrc     = 1'b1;
        dec_alucontrol = 3'b010;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next state for the pipeline registers, counter and sticky flag
  always_comb begin
    e_d = '0;
    if (flushE) begin
      e_d = '0;
    end else begin
      e_d.regwrite   = dec_regwrite;
      e_d.memtoreg   = dec_memtoreg;
      e_d.memwrite   = dec_memwrite;
      e_d.alusrc     = dec_alusrc;
      e_d.regdst     = dec_regdst;
      e_d.alucontrol = dec_alucontrol;
      e_d.valid      = ~dec_illegal;
    end
    m_d.regwrite   = e_q.regwrite;
    m_d.memtoreg   = e_q.memtoreg;
    m_d.memwrite   = e_q.memwrite;
    m_d.valid      = e_q.valid;
    w_d.regwrite   = m_q.regwrite;
    w_d.memtoreg   = m_q.memtoreg;
    w_d.valid      = m_q.valid;
    instret_d      = instret_q + {31'd0, w_q.valid};
    illegal_seen_d = illegal_seen_q | (dec_illegal & ~flushE);
  end

  // State registers; reset wins over flush and counting
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q            <= '0;
      m_q            <= '0;
      w_q            <= '0;
      instret_q      <= 32'd0;
      illegal_seen_q <= 1'b0;
    end else begin
      e_q            <= e_d;
      m_q            <= m_d;
      w_q            <= w_d;
      instret_q      <= instret_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign jumpD        = dec_jump;
  assign branchD      = dec_branch;
  assign illegalD     = dec_illegal;
  assign regwriteE    = e_q.regwrite;
  assign memtoregE    = e_q.memtoreg;
  assign alusrcE      = e_q.alusrc;
  assign regdstE      = e_q.regdst;
  assign alucontrolE  = e_q.alucontrol;
  assign regwriteM    = m_q.regwrite;
  assign memtoregM    = m_q.memtoreg;
  assign memwriteM    = m_q.memwrite;
  assign regwriteW    = w_q.regwrite;
  assign memtoregW    = w_q.memtoreg;
  assign instret      = instret_q;
  assign illegal_seen = illegal_seen_q;

endmodule
